// File: rtl/alu_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_operand_stage: forwarding-aware ALU operand select with load-use stall |
// | and a registered valid/ready output stage.          Rev 1.0               |
// +----------------------------------------------------------------------------+
module alu_operand_stage #(
  parameter int XLEN      = 32,
  parameter int NUM_FWD   = 3,
  parameter int REG_IDX_W = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [2:0]                   alu_src_sel_i,
  input  logic [REG_IDX_W-1:0]         rs1_idx_i,
  input  logic [REG_IDX_W-1:0]         rs2_idx_i,
  input  logic [XLEN-1:0]              reg1_rd_data_i,
  input  logic [XLEN-1:0]              reg2_rd_data_i,
  input  logic [XLEN-1:0]              csr_rd_data_i,
  input  logic [XLEN-1:0]              imm_i,
  input  logic [XLEN-1:0]              curr_pc_i,
  input  logic [NUM_FWD-1:0]           fwd_valid_i,
  input  logic [NUM_FWD-1:0]           fwd_pending_i,
  input  logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd_idx_i,
  input  logic [NUM_FWD*XLEN-1:0]      fwd_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [XLEN-1:0]              alu_src1_o,
  output logic [XLEN-1:0]              alu_src2_o,
  output logic                         hazard_o
);

  localparam logic [2:0] c_sel_reg       = 3'd0;
  localparam logic [2:0] c_sel_imm       = 3'd1;
  localparam logic [2:0] c_sel_four_pc   = 3'd2;
  localparam logic [2:0] c_sel_imm_pc    = 3'd3;
  localparam logic [2:0] c_sel_csr_reg   = 3'd4;
  localparam logic [2:0] c_sel_csrin_reg = 3'd5;
  localparam logic [2:0] c_sel_csr_imm   = 3'd6;
  localparam logic [XLEN-1:0] c_four     = XLEN'(4);

  logic [REG_IDX_W-1:0] w_fwd_rd   [NUM_FWD];
  logic [XLEN-1:0]      w_fwd_data [NUM_FWD];

  for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd_unpack
    assign w_fwd_rd[k]   = fwd_rd_idx_i[k*REG_IDX_W +: REG_IDX_W];
    assign w_fwd_data[k] = fwd_data_i[k*XLEN +: XLEN];
  end

  logic [XLEN-1:0] w_op1, w_op2;
  logic            w_pend1, w_pend2;

  // Walk oldest to youngest so the youngest match is the last one to win.
  always_comb begin
    w_op1   = reg1_rd_data_i;
    w_op2   = reg2_rd_data_i;
    w_pend1 = 1'b0;
    w_pend2 = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid_i[k] && (w_fwd_rd[k] == rs1_idx_i) && (rs1_idx_i != '0)) begin
        w_pend1 = fwd_pending_i[k];
        if (!fwd_pending_i[k]) w_op1 = w_fwd_data[k];
      end
      if (fwd_valid_i[k] && (w_fwd_rd[k] == rs2_idx_i) && (rs2_idx_i != '0)) begin
        w_pend2 = fwd_pending_i[k];
        if (!fwd_pending_i[k]) w_op2 = w_fwd_data[k];
      end
    end
  end

  logic w_rs1_used, w_rs2_used;
  assign w_rs1_used = (alu_src_sel_i == c_sel_reg)     || (alu_src_sel_i == c_sel_imm)  ||
                      (alu_src_sel_i == c_sel_csr_reg) || (alu_src_sel_i == c_sel_csrin_reg) ||
                      (alu_src_sel_i == 3'd7);
  assign w_rs2_used = (alu_src_sel_i == c_sel_reg) || (alu_src_sel_i == 3'd7);

  assign hazard_o = (w_rs1_used & w_pend1) | (w_rs2_used & w_pend2);

  logic [XLEN-1:0] w_src1, w_src2;

  always_comb begin
    w_src1 = w_op1;
    w_src2 = w_op2;
    case (alu_src_sel_i)
      c_sel_imm:       begin w_src1 = w_op1;         w_src2 = imm_i;         end
      c_sel_four_pc:   begin w_src1 = c_four;        w_src2 = curr_pc_i;     end
      c_sel_imm_pc:    begin w_src1 = curr_pc_i;     w_src2 = imm_i;         end
      c_sel_csr_reg:   begin w_src1 = w_op1;         w_src2 = csr_rd_data_i; end
      c_sel_csrin_reg: begin w_src1 = ~w_op1;        w_src2 = csr_rd_data_i; end
      c_sel_csr_imm:   begin w_src1 = csr_rd_data_i; w_src2 = imm_i;         end
      default:         begin w_src1 = w_op1;         w_src2 = w_op2;         end
    endcase
  end

  logic            r_valid;
  logic [XLEN-1:0] r_src1, r_src2;
  logic            w_capture;

  assign in_ready_o = (~r_valid | out_ready_i) & ~hazard_o & ~flush_i;
  assign w_capture  = in_valid_i & in_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_src1  <= '0;
      r_src2  <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_src1  <= w_src1;
      r_src2  <= w_src2;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_valid;
  assign alu_src1_o  = r_src1;
  assign alu_src2_o  = r_src2;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_operand_stage: directed vectors with hand-computed expectations.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_alu_operand_stage;

  localparam int XLEN      = 32;
  localparam int NUM_FWD   = 3;
  localparam int REG_IDX_W = 5;

  logic                         clk;
  logic                         rst_n;
  logic                         flush_i;
  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [2:0]                   alu_src_sel_i;
  logic [REG_IDX_W-1:0]         rs1_idx_i, rs2_idx_i;
  logic [XLEN-1:0]              reg1_rd_data_i, reg2_rd_data_i, csr_rd_data_i, imm_i, curr_pc_i;
  logic [NUM_FWD-1:0]           fwd_valid_i, fwd_pending_i;
  logic [NUM_FWD*REG_IDX_W-1:0] fwd_rd_idx_i;
  logic [NUM_FWD*XLEN-1:0]      fwd_data_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [XLEN-1:0]              alu_src1_o, alu_src2_o;
  logic                         hazard_o;

  alu_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_IDX_W(REG_IDX_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_src_sel_i(alu_src_sel_i), .rs1_idx_i(rs1_idx_i), .rs2_idx_i(rs2_idx_i),
    .reg1_rd_data_i(reg1_rd_data_i), .reg2_rd_data_i(reg2_rd_data_i),
    .csr_rd_data_i(csr_rd_data_i), .imm_i(imm_i), .curr_pc_i(curr_pc_i),
    .fwd_valid_i(fwd_valid_i), .fwd_pending_i(fwd_pending_i),
    .fwd_rd_idx_i(fwd_rd_idx_i), .fwd_data_i(fwd_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .hazard_o(hazard_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_fwd(input int k, input logic v, input logic p,
                         input logic [REG_IDX_W-1:0] rd, input logic [XLEN-1:0] d);
    fwd_valid_i[k]                         = v;
    fwd_pending_i[k]                       = p;
    fwd_rd_idx_i[k*REG_IDX_W +: REG_IDX_W] = rd;
    fwd_data_i[k*XLEN +: XLEN]             = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mode table: sel, expected src1, expected src2 for the fixed operands below.
  logic [2:0]      m_sel [5] = '{3'd2, 3'd5, 3'd6, 3'd4, 3'd7};
  logic [XLEN-1:0] m_s1  [5] = '{32'h4, 32'hFFFF_FFF0, 32'hF0, 32'h0F, 32'h0F};
  logic [XLEN-1:0] m_s2  [5] = '{32'h8000_0010, 32'hF0, 32'h20, 32'hF0, 32'h99};

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    alu_src_sel_i = 3'd0; rs1_idx_i = '0; rs2_idx_i = '0;
    reg1_rd_data_i = '0; reg2_rd_data_i = '0; csr_rd_data_i = '0; imm_i = '0; curr_pc_i = '0;
    fwd_valid_i = '0; fwd_pending_i = '0; fwd_rd_idx_i = '0; fwd_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(out_valid_o), 32'h0);
    check_eq("rst_src1", alu_src1_o, 32'h0);
    check_eq("rst_src2", alu_src2_o, 32'h0);
    rst_n = 1'b1;

    // Forwarding priority: youngest match wins, rs2=0 never forwarded.
    step();
    alu_src_sel_i = 3'd0; rs1_idx_i = 5'd5; rs2_idx_i = 5'd0;
    reg1_rd_data_i = 32'h1111; reg2_rd_data_i = 32'h2222;
    set_fwd(0, 1'b1, 1'b0, 5'd5, 32'hAAAA);
    set_fwd(1, 1'b1, 1'b0, 5'd0, 32'hCCCC);
    set_fwd(2, 1'b1, 1'b0, 5'd5, 32'hBBBB);
    in_valid_i = 1'b1;
    #1;
    check_eq("prio_hazard", 32'(hazard_o), 32'h0);
    check_eq("prio_ready", 32'(in_ready_o), 32'h1);
    step();
    check_eq("prio_valid", 32'(out_valid_o), 32'h1);
    check_eq("prio_src1", alu_src1_o, 32'hAAAA);
    check_eq("prio_src2", alu_src2_o, 32'h2222);
    in_valid_i = 1'b0;
    step();
    check_eq("drain_valid", 32'(out_valid_o), 32'h0);

    // Load-use stall on rs1 in IMM mode.
    alu_src_sel_i = 3'd1; rs1_idx_i = 5'd7; rs2_idx_i = 5'd9; imm_i = 32'h55;
    set_fwd(0, 1'b1, 1'b0, 5'd3, 32'h3333);
    set_fwd(1, 1'b1, 1'b1, 5'd7, 32'hDEAD);
    set_fwd(2, 1'b0, 1'b0, 5'd0, 32'h0);
    in_valid_i = 1'b1;
    #1;
    check_eq("lu_hazard", 32'(hazard_o), 32'h1);
    check_eq("lu_ready", 32'(in_ready_o), 32'h0);
    step();
    check_eq("lu_nocap", 32'(out_valid_o), 32'h0);
    set_fwd(1, 1'b1, 1'b0, 5'd7, 32'h1234);
    #1;
    check_eq("lu_clr_hazard", 32'(hazard_o), 32'h0);
    step();
    check_eq("lu_valid", 32'(out_valid_o), 32'h1);
    check_eq("lu_src1", alu_src1_o, 32'h1234);
    check_eq("lu_src2", alu_src2_o, 32'h55);

    // IMM_PC does not read rs1, so a pending match is not a hazard.
    alu_src_sel_i = 3'd3; curr_pc_i = 32'h100;
    set_fwd(1, 1'b1, 1'b1, 5'd7, 32'hDEAD);
    #1;
    check_eq("immpc_hazard", 32'(hazard_o), 32'h0);
    check_eq("immpc_ready", 32'(in_ready_o), 32'h1);
    step();
    check_eq("immpc_src1", alu_src1_o, 32'h100);
    check_eq("immpc_src2", alu_src2_o, 32'h55);

    // Younger non-pending match overrides older pending match.
    alu_src_sel_i = 3'd0; rs2_idx_i = 5'd0; reg2_rd_data_i = 32'h2222;
    set_fwd(0, 1'b1, 1'b0, 5'd7, 32'h777);
    #1;
    check_eq("ovr_hazard", 32'(hazard_o), 32'h0);
    step();
    check_eq("ovr_src1", alu_src1_o, 32'h777);

    // Mode table, back-to-back captures.
    fwd_valid_i = '0; fwd_pending_i = '0;
    rs1_idx_i = 5'd1; rs2_idx_i = 5'd2;
    reg1_rd_data_i = 32'h0F; reg2_rd_data_i = 32'h99; curr_pc_i = 32'h8000_0010;
    imm_i = 32'h20; csr_rd_data_i = 32'hF0;
    for (int i = 0; i < 5; i++) begin
      alu_src_sel_i = m_sel[i];
      step();
      check_eq($sformatf("mode%0d_valid", m_sel[i]), 32'(out_valid_o), 32'h1);
      check_eq($sformatf("mode%0d_src1", m_sel[i]), alu_src1_o, m_s1[i]);
      check_eq($sformatf("mode%0d_src2", m_sel[i]), alu_src2_o, m_s2[i]);
    end

    // Backpressure: held outputs stay stable, no acceptance.
    out_ready_i = 1'b0; alu_src_sel_i = 3'd0;
    reg1_rd_data_i = 32'hA1; reg2_rd_data_i = 32'hA2;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_ready", 32'(in_ready_o), 32'h0);
      step();
      check_eq("bp_valid", 32'(out_valid_o), 32'h1);
      check_eq("bp_src1", alu_src1_o, 32'h0F);
      check_eq("bp_src2", alu_src2_o, 32'h99);
    end
    out_ready_i = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(in_ready_o), 32'h1);
    step();
    check_eq("b2b0_valid", 32'(out_valid_o), 32'h1);
    check_eq("b2b0_src1", alu_src1_o, 32'hA1);
    reg1_rd_data_i = 32'hB1; reg2_rd_data_i = 32'hB2;
    step();
    check_eq("b2b1_valid", 32'(out_valid_o), 32'h1);
    check_eq("b2b1_src1", alu_src1_o, 32'hB1);
    check_eq("b2b1_src2", alu_src2_o, 32'hB2);

    // Flush with held data and a live request.
    reg1_rd_data_i = 32'hC1; flush_i = 1'b1;
    #1;
    check_eq("flush_ready", 32'(in_ready_o), 32'h0);
    step();
    check_eq("flush_valid", 32'(out_valid_o), 32'h0);
    flush_i = 1'b0; in_valid_i = 1'b0;
    step();
    check_eq("flush_nocap", 32'(out_valid_o), 32'h0);

    // Asynchronous reset mid-cycle while holding operands.
    reg1_rd_data_i = 32'hD1; reg2_rd_data_i = 32'hD2; in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0; out_ready_i = 1'b0;
    check_eq("pre_rst_valid", 32'(out_valid_o), 32'h1);
    check_eq("pre_rst_src1", alu_src1_o, 32'hD1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(out_valid_o), 32'h0);
    check_eq("arst_src1", alu_src1_o, 32'h0);
    check_eq("arst_src2", alu_src2_o, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Parametrised ALU operand selector with operand forwarding, load-use hazard detection and a registered valid/ready output stage. It sits between decode/register-read and execute. It resolves rs1/rs2 against NUM_FWD in-flight result sources, applies the ALU source-select mode to form src1/src2, and holds them in a pipeline register that supports backpressure and flush.

Parameters:
XLEN, 32, datapath width of all operand/result buses
NUM_FWD, 3, number of forwarding sources; index 0 = youngest (highest priority)
REG_IDX_W, 5, register index width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
flush_i  in  1  discard held and incoming operands
in_valid_i  in  1  upstream operand request valid
in_ready_o  out  1  block accepts request this cycle
alu_src_sel_i  in  3  source mode: 0 REG, 1 IMM, 2 FOUR_PC, 3 IMM_PC, 4 CSR_REG, 5 CSRIN_REG, 6 CSR_IMM, 7 reserved
rs1_idx_i  in  REG_IDX_W  rs1 index
rs2_idx_i  in  REG_IDX_W  rs2 index
reg1_rd_data_i  in  XLEN  register-file rs1 data
reg2_rd_data_i  in  XLEN  register-file rs2 data
csr_rd_data_i  in  XLEN  CSR read data
imm_i  in  XLEN  decoded immediate
curr_pc_i  in  XLEN  PC of instruction
fwd_valid_i  in  NUM_FWD  source k writes a register
fwd_pending_i  in  NUM_FWD  source k result not yet available (load in flight)
fwd_rd_idx_i  in  NUM_FWD*REG_IDX_W  destination index, source k at [k*REG_IDX_W +: REG_IDX_W]
fwd_data_i  in  NUM_FWD*XLEN  result data, source k at [k*XLEN +: XLEN]
out_valid_o  out  1  registered operands valid
out_ready_i  in  1  execute accepts operands
alu_src1_o  out  XLEN  registered ALU source 1
alu_src2_o  out  XLEN  registered ALU source 2
hazard_o  out  1  combinational load-use stall indicator

Behaviour:
- Reset (rst_n low, async): out_valid_o=0, alu_src1_o=0, alu_src2_o=0. hazard_o and in_ready_o are combinational.
- Operand resolution (combinational): op1 = data of the lowest k with fwd_valid[k] & ~fwd_pending[k] & rd_idx[k]==rs1_idx & rs1_idx!=0; otherwise reg1_rd_data_i. op2 is resolved the same way from rs2. Index 0 is never forwarded.
- Usage by mode: rs1 used in modes 0,1,4,5,7; rs2 used in modes 0,7 only.
- hazard_o=1 when, for a used rs with nonzero index, the lowest-index matching valid source has fwd_pending=1. A younger non-pending match overrides an older pending match.
- Mode mapping (src1/src2):
  - 0 REG: op1/op2
  - 1 IMM: op1/imm
  - 2 FOUR_PC: 4/curr_pc
  - 3 IMM_PC: curr_pc/imm
  - 4 CSR_REG: op1/csr
  - 5 CSRIN_REG: ~op1/csr
  - 6 CSR_IMM: csr/imm
  - 7: same as 0
- Arithmetic: XLEN bits, constant 4 zero-extended, ~ is bitwise over XLEN.
- Handshake:
  - in_ready_o = (~out_valid_o | out_ready_i) & ~hazard_o & ~flush_i.
  - Capture on in_valid_i & in_ready_o. Operands are registered next edge; latency is 1 cycle.
  - If out_valid_o & out_ready_i with no capture, out_valid_o clears.
  - While out_valid_o & ~out_ready_i, outputs hold stable.
  - in_valid_i may drop without acceptance; no state is kept for unaccepted requests.
- Flush: out_valid_o<=0 next edge. No capture in the flush cycle. Data regs may keep stale values.
- Simultaneous drain+capture: out_valid_o stays 1 with new data (full throughput, no bubble).
- Reset mid-operation clears any held operands immediately.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with out_valid_o=1 -> out_valid_o=0 and src1/src2=0 immediately.
- Forwarding priority, mode 0: rs1=5 with fwd0 (rd5, 0xAAAA) and fwd2 (rd5, 0xBBBB) valid -> src1=0xAAAA. rs2=0 with fwd1 rd0 valid -> src2=reg2_rd_data.
- Load-use: mode 1, rs1=7, fwd1 valid+pending rd7, fwd0 not matching -> hazard_o=1, in_ready_o=0. Clear pending with data 0x1234 -> accepted next cycle, src1=0x1234, src2=imm. Repeat with mode 3 -> no hazard.
- Modes: curr_pc=0x80000010, imm=0x20, csr=0xF0, reg1=0x0F -> mode2 gives 4/0x80000010; mode5 gives 0xFFFFFFF0/0xF0; mode6 gives 0xF0/0x20.
- Backpressure: out_ready_i=0 for 3 cycles with in_valid_i=1 -> outputs stable, in_ready_o=0. Raise out_ready_i -> back-to-back transfers on consecutive cycles with no bubble.
- Flush: flush_i=1 while out_valid_o=1 and in_valid_i=1 -> out_valid_o=0 next cycle and no capture.
